// File: rtl/estimate_seq.sv
// rtl/estimate_seq.sv - command/address sequencer for the binary-neuron estimate core
module estimate_seq #(
  parameter int              AW        = 10,
  parameter int              CW        = 8,
  parameter logic [AW-1:0]   BIAS_BASE = 10'h380,
  parameter logic [AW-1:0]   NORM_BASE = 10'h3C0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [CW-1:0] n_acc,
  input  logic [CW-1:0] n_pool,
  input  logic [CW-1:0] n_out,
  input  logic          stall,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] d_addr,
  output logic [AW-1:0] p_addr,
  output logic [2:0]    com_1,
  output logic          activ_vld,
  output logic [CW-1:0] activ_idx
);

  typedef enum logic [2:0] {IDLE, INI, ACC, POOL, NORM, ACTV, DRAIN} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] k_lat, p_lat, n_lat;
  logic [CW-1:0] k_cnt, w_cnt, n_cnt;
  logic [AW-1:0] dptr;      // running feature address w*K+k
  logic [AW-1:0] pbase;     // running weight base n*K
  logic [1:0]    drain_cnt;
  logic          zero_done;
  logic [2:0]    av;
  logic [CW-1:0] ai [3];

  logic          issue, start_ok, start_zero;
  logic          k_last, w_last, n_last;
  logic [2:0]    cmd;
  logic [AW-1:0] n_ext;

  assign k_last = (k_cnt == k_lat - CW'(1));
  assign w_last = (w_cnt == p_lat - CW'(1));
  assign n_last = (n_cnt == n_lat - CW'(1));
  assign n_ext  = AW'(n_cnt);

  assign busy      = (state != IDLE);
  assign done      = zero_done | ((state == DRAIN) && (drain_cnt == 2'd2));
  assign activ_vld = av[2];
  assign activ_idx = ai[2];

  // Next-state, issue qualifier and command decode for the current state
  always_comb begin
    state_nxt  = state;
    cmd        = 3'd7;
    issue      = 1'b0;
    start_ok   = 1'b0;
    start_zero = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (n_acc != '0 && n_pool != '0 && n_out != '0) begin
            start_ok  = 1'b1;
            state_nxt = INI;
          end else begin
            start_zero = 1'b1;
          end
        end
      end
      INI: begin
        cmd   = 3'd0;
        issue = !stall;
        if (issue) state_nxt = ACC;
      end
      ACC: begin
        cmd   = 3'd1;
        issue = !stall;
        if (issue && k_last) state_nxt = POOL;
      end
      POOL: begin
        cmd   = 3'd2;
        issue = !stall;
        if (issue) state_nxt = w_last ? NORM : ACC;
      end
      NORM: begin
        cmd   = 3'd3;
        issue = !stall;
        if (issue) state_nxt = ACTV;
      end
      ACTV: begin
        cmd   = 3'd4;
        issue = !stall;
        if (issue) state_nxt = n_last ? DRAIN : INI;
      end
      DRAIN: begin
        if (drain_cnt == 2'd2) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Counters and the address registers, loaded with the address of the state being entered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_lat     <= '0;
      p_lat     <= '0;
      n_lat     <= '0;
      k_cnt     <= '0;
      w_cnt     <= '0;
      n_cnt     <= '0;
      dptr      <= '0;
      pbase     <= '0;
      drain_cnt <= '0;
      zero_done <= 1'b0;
      d_addr    <= '0;
      p_addr    <= '0;
    end else begin
      zero_done <= start_zero;
      drain_cnt <= (state == DRAIN) ? drain_cnt + 2'd1 : 2'd0;
      if (start_ok) begin
        k_lat  <= n_acc;
        p_lat  <= n_pool;
        n_lat  <= n_out;
        n_cnt  <= '0;
        pbase  <= '0;
        d_addr <= BIAS_BASE;
      end
      if (issue) begin
        case (state)
          INI: begin
            k_cnt  <= '0;
            w_cnt  <= '0;
            dptr   <= '0;
            d_addr <= '0;
            p_addr <= pbase;
          end
          ACC: begin
            dptr <= dptr + AW'(1);
            if (k_last) begin
              d_addr <= BIAS_BASE + n_ext;
            end else begin
              k_cnt  <= k_cnt + CW'(1);
              d_addr <= dptr + AW'(1);
              p_addr <= pbase + AW'(k_cnt) + AW'(1);
            end
          end
          POOL: begin
            if (w_last) begin
              p_addr <= NORM_BASE + n_ext;
            end else begin
              w_cnt  <= w_cnt + CW'(1);
              k_cnt  <= '0;
              d_addr <= dptr;
              p_addr <= pbase;
            end
          end
          ACTV: begin
            if (!n_last) begin
              n_cnt  <= n_cnt + CW'(1);
              pbase  <= pbase + AW'(k_lat);
              d_addr <= BIAS_BASE + n_ext + AW'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Command register: one cycle behind issue to line up with synchronous memory reads
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) com_1 <= 3'd7;
    else        com_1 <= issue ? cmd : 3'd7;
  end

  // Activation strobe pipeline; runs freely so stall cannot lose a pending result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      av    <= '0;
      ai[0] <= '0;
      ai[1] <= '0;
      ai[2] <= '0;
    end else begin
      av    <= {av[1:0], issue && (state == ACTV)};
      ai[0] <= n_cnt;
      ai[1] <= ai[0];
      ai[2] <= ai[1];
    end
  end

endmodule

// File: tb/tb_estimate_seq.sv
// tb/tb_estimate_seq.sv - randomized self-checking bench for estimate_seq
module tb_estimate_seq;

  localparam logic [9:0] BIAS = 10'h380;
  localparam logic [9:0] NORMB = 10'h3C0;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] n_acc, n_pool, n_out;
  logic       stall;
  logic       busy, done;
  logic [9:0] d_addr, p_addr;
  logic [2:0] com_1;
  logic       activ_vld;
  logic [7:0] activ_idx;

  int n_checks = 0;
  int n_fail   = 0;
  logic [9:0] last_d, last_p;

  typedef struct {
    int         cmd;
    logic [9:0] d;
    logic [9:0] p;
    int         nn;
  } ent_t;

  ent_t lst[$];

  estimate_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .n_acc     (n_acc),
    .n_pool    (n_pool),
    .n_out     (n_out),
    .stall     (stall),
    .busy      (busy),
    .done      (done),
    .d_addr    (d_addr),
    .p_addr    (p_addr),
    .com_1     (com_1),
    .activ_vld (activ_vld),
    .activ_idx (activ_idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_d", 32'(d_addr), 0);
    chk("rst_p", 32'(p_addr), 0);
    chk("rst_com", 32'(com_1), 7);
    chk("rst_vld", 32'(activ_vld), 0);
    chk("rst_idx", 32'(activ_idx), 0);
  endtask

  // Expected issue list: every command of the run with the addresses visible while it is pending
  task automatic build(input int K, input int P, input int N);
    logic [9:0] cd, cp;
    cd = last_d;
    cp = last_p;
    lst.delete();
    for (int n = 0; n < N; n++) begin
      cd = BIAS + 10'(n);
      lst.push_back('{0, cd, cp, n});
      for (int w = 0; w < P; w++) begin
        for (int k = 0; k < K; k++) begin
          cd = 10'(w * K + k);
          cp = 10'(n * K + k);
          lst.push_back('{1, cd, cp, n});
        end
        cd = BIAS + 10'(n);
        lst.push_back('{2, cd, cp, n});
      end
      cp = NORMB + 10'(n);
      lst.push_back('{3, cd, cp, n});
      lst.push_back('{4, cd, cp, n});
    end
  endtask

  task automatic run(input int K, input int P, input int N, input int stall_pct,
                     input int stall_from, input bit restart);
    int idx, pc, t_done, c;
    int pend_t[$];
    int pend_n[$];
    build(K, P, N);
    start  = 1'b1;
    n_acc  = 8'(K);
    n_pool = 8'(P);
    n_out  = 8'(N);
    stall  = 1'($urandom_range(0, 1));
    step();
    start  = 1'b0;
    n_acc  = 8'($urandom);
    n_pool = 8'($urandom);
    n_out  = 8'($urandom);
    idx = 0; pc = 7; t_done = -1; c = 1;
    forever begin
      chk("busy", 32'(busy), (t_done < 0 || c <= t_done) ? 1 : 0);
      if (idx < lst.size()) begin
        chk("d_addr", 32'(d_addr), 32'(lst[idx].d));
        chk("p_addr", 32'(p_addr), 32'(lst[idx].p));
      end
      chk("com_1", 32'(com_1), 32'(pc));
      if (pend_t.size() > 0 && pend_t[0] == c) begin
        chk("activ_vld", 32'(activ_vld), 1);
        chk("activ_idx", 32'(activ_idx), 32'(pend_n[0]));
        void'(pend_t.pop_front());
        void'(pend_n.pop_front());
      end else begin
        chk("activ_vld", 32'(activ_vld), 0);
      end
      chk("done", 32'(done), (c == t_done) ? 1 : 0);
      if (t_done >= 0 && c > t_done) break;
      stall = ($urandom_range(0, 99) < stall_pct) || c == stall_from || c == stall_from + 1;
      if (restart && c == 5) begin
        start  = 1'b1;
        n_acc  = 8'($urandom_range(0, 3));
        n_pool = 8'($urandom_range(0, 3));
        n_out  = 8'($urandom_range(0, 3));
      end
      if (idx < lst.size() && !stall) begin
        pc = lst[idx].cmd;
        if (pc == 4) begin
          pend_t.push_back(c + 3);
          pend_n.push_back(lst[idx].nn);
        end
        if (idx == lst.size() - 1) t_done = c + 3;
        idx++;
      end else begin
        pc = 7;
      end
      step();
      start = 1'b0;
      c++;
      if (c > 8000) begin
        chk("run_timeout", 32'(c), 0);
        break;
      end
    end
    stall  = 1'b0;
    last_d = lst[lst.size() - 1].d;
    last_p = lst[lst.size() - 1].p;
  endtask

  task automatic zero_run(input int K, input int P, input int N);
    logic [9:0] d0, p0;
    d0 = d_addr;
    p0 = p_addr;
    start  = 1'b1;
    n_acc  = 8'(K);
    n_pool = 8'(P);
    n_out  = 8'(N);
    step();
    start = 1'b0;
    chk("zero_done", 32'(done), 1);
    chk("zero_busy", 32'(busy), 0);
    chk("zero_com", 32'(com_1), 7);
    step();
    chk("zero_done2", 32'(done), 0);
    chk("zero_busy2", 32'(busy), 0);
    chk("zero_com2", 32'(com_1), 7);
    chk("zero_d", 32'(d_addr), 32'(d0));
    chk("zero_p", 32'(p_addr), 32'(p0));
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    n_acc = '0;
    n_pool = '0;
    n_out = '0;
    stall = 1'b0;
    last_d = '0;
    last_p = '0;
    step();
    step();
    chk_reset_vals();
    rst_n = 1'b1;
    step();

    run(2, 2, 1, 0, -1, 1'b0);
    run(3, 1, 3, 0, -1, 1'b0);
    run(2, 1, 1, 0, 3, 1'b0);
    zero_run(3, 0, 2);
    zero_run(0, 2, 2);
    zero_run(2, 2, 0);
    run(2, 2, 2, 0, -1, 1'b1);
    for (int i = 0; i < 10; i++) begin
      run($urandom_range(1, 6), $urandom_range(1, 4), $urandom_range(1, 4),
          $urandom_range(0, 40), -1, 1'($urandom_range(0, 1)));
    end
    run(200, 1, 6, 15, -1, 1'b0);
    run(255, 5, 1, 10, -1, 1'b0);

    // Abort part-way through an accumulation
    start  = 1'b1;
    n_acc  = 8'd4;
    n_pool = 8'd2;
    n_out  = 8'd2;
    step();
    start = 1'b0;
    step();
    step();
    step();
    rst_n = 1'b0;
    #1;
    chk_reset_vals();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("post_rst_vld", 32'(activ_vld), 0);
      chk("post_rst_done", 32'(done), 0);
      chk("post_rst_com", 32'(com_1), 7);
      chk("post_rst_busy", 32'(busy), 0);
    end
    last_d = '0;
    last_p = '0;
    run(1, 2, 1, 20, -1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/estimate_seq.md
Name: estimate_seq

Overview:
- Command sequencer for the binary-neuron estimate datapath (ini/acc/pool/norm/activ command core).
- For each output neuron it issues: ini, then P pooling windows of K acc commands each followed by one pool, then norm and activ.
- It generates feature-memory and parameter-memory read addresses, and presents the aligned 3-bit command one cycle later to match synchronous-read memory latency.
- It flags each neuron's activation result when the core's activ output becomes valid.

Parameters:
- AW, 10, address width of d_addr and p_addr.
- CW, 8, width of the count inputs and of activ_idx.
- BIAS_BASE, 10'h380, data-memory base of per-neuron init/bias words.
- NORM_BASE, 10'h3C0, param-memory base of per-neuron norm words.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request; accepted only when busy=0.
- n_acc  in  CW  K, acc words per pool window; latched on accepted start.
- n_pool  in  CW  P, pool windows per neuron; latched on start.
- n_out  in  CW  N, neurons per run; latched on start.
- stall  in  1  hold issue (memory or data not ready).
- busy  out  1  high from the cycle after an accepted start through the done cycle.
- done  out  1  one-cycle pulse at end of run.
- d_addr  out  AW  feature/bias memory read address.
- p_addr  out  AW  weight/norm memory read address.
- com_1  out  3  command to core: 0 ini, 1 acc, 2 pool, 3 norm, 4 activ, 7 NOP.
- activ_vld  out  1  core activ output valid this cycle.
- activ_idx  out  CW  neuron index belonging to activ_vld.

Behaviour:
- Reset values: busy=0, done=0, d_addr=0, p_addr=0, com_1=7, activ_vld=0, activ_idx=0; state IDLE; all counters 0. Reset mid-run aborts immediately; no done is issued.
- States: IDLE, INI, ACC, POOL, NORM, ACTV, DRAIN.
- Transitions:
  - IDLE -> INI on start with all counts nonzero.
  - INI -> ACC.
  - ACC -> ACC while k<K-1; at k=K-1 -> POOL.
  - POOL -> ACC while w<P-1; at w=P-1 -> NORM.
  - NORM -> ACTV.
  - ACTV -> INI for the next neuron if n<N-1; otherwise -> DRAIN.
  - DRAIN -> IDLE after 3 cycles.
- Zero-count start (K, P or N = 0): no commands issued; done pulses the next cycle; busy stays 0.
- Addresses (issued in the state cycle), all arithmetic by running adders, truncated modulo 2^AW (wrap, no error):
  - INI and POOL: d_addr = BIAS_BASE + n.
  - ACC: d_addr = w*K + k; p_addr = n*K + k. Weights are shared across windows.
  - NORM: p_addr = NORM_BASE + n.
  - ACTV: addresses hold.
- Command alignment: com_1 is registered and equals the command of the previous cycle's issued state; otherwise 7.
  - Addresses issued in cycle t give com_1 valid in t+1.
- Stall: a state issues only when stall=0. While stall=1, state, counters and addresses hold, and com_1 becomes 7 in the next cycle. Stall in IDLE and DRAIN has no effect.
- Activation strobe: if ACTV is issued in cycle t, then com_1=4 in t+1, the core latches activ at the end of t+2, and activ_vld=1 with activ_idx=n in t+3.
  - This is implemented as a 3-deep valid/index shift register that is not frozen by stall.
- done pulses in the same cycle as the last activ_vld; busy drops the following cycle.
- Commands per neuron = K*P + P + 3.
- start while busy=1 is ignored. Config changes after start are ignored.

Test Plan:
- Basic run: K=2, P=2, N=1 with no stall -> com_1 sequence 0,1,1,2,1,1,2,3,4 in consecutive cycles. The acc d_addr values are 0,1,2,3; the acc p_addr values are 0,1,0,1; the ini/pool d_addr is 0x380; the norm p_addr is 0x3C0. activ_vld and done are high 3 cycles after ACTV issue with activ_idx=0.
- Multi-neuron: K=3, P=1, N=3 -> 3 activ_vld pulses with idx 0,1,2, spaced 7 cycles apart. Neuron 2's acc p_addr values are 6,7,8; done coincides with idx 2.
- Stall: K=2, P=1, N=1 with stall held 2 cycles after the first acc issue -> com_1 shows 7,7 at those slots, and the remaining sequence and addresses are unchanged.
- Zero count: n_pool=0 -> no non-7 com_1; done pulses 1 cycle after start; busy stays 0.
- Start while busy, plus reset mid-run: a second start mid-run is ignored (one done only). Asserting rst_n=0 during ACC -> all outputs at reset values immediately; no done or activ_vld afterwards.
- End-to-end with the core model: K=1, P=2, N=1 with random data/weights -> the activ captured at activ_vld matches the golden popcount/max/norm sign.
